// File: rtl/sprite_rom_reader_if.sv
// ROM read port between the sprite reader and the image ROM.
// The reader (master) drives an address every clock. The ROM (slave) returns
// the pixel at that address one clock later. There is no valid/ready pair:
// the bus never stalls, and the data always lags the address by exactly one
// cycle.
interface sprite_rom_reader_if;
    logic [11:0] rom_addr;
    logic [11:0] rom_rgb;

    modport master (output rom_addr, input rom_rgb);
    modport slave  (input rom_addr, output rom_rgb);
endinterface

// File: rtl/sprite_rom_reader.sv
// Sprite overlay stage for the VGA draw chain.
// For each raster position it decides whether the pixel lies inside the
// sprite window, addresses the image ROM and composites the returned colour
// over the background. Every timing signal is delayed 3 clocks so it stays
// aligned with the registered ROM read. The sprite position is
// double-buffered and only takes effect at a vsync rising edge.
module sprite_rom_reader #(
    parameter int          WIDTH        = 48,
    parameter int          HEIGHT       = 64,
    parameter bit          TRANSP_EN    = 1'b1,
    parameter logic [11:0] TRANSP_COLOR = 12'h000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [10:0]         hcount_in,
    input  logic [10:0]         vcount_in,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic                hblnk_in,
    input  logic                vblnk_in,
    input  logic [11:0]         rgb_in,
    input  logic [11:0]         xpos,
    input  logic [11:0]         ypos,
    input  logic                pos_valid,
    sprite_rom_reader_if.master rom,
    output logic [10:0]         hcount_out,
    output logic [10:0]         vcount_out,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic                hblnk_out,
    output logic                vblnk_out,
    output logic [11:0]         rgb_out
);

    localparam logic [12:0] W13 = 13'(WIDTH);
    localparam logic [12:0] H13 = 13'(HEIGHT);

    // Timing bundle carried down the pipeline: {hcount, vcount, hs, vs, hb, vb}
    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } timing_t;

    logic        vsync_q;
    logic [11:0] act_x_q, act_y_q;
    logic [11:0] pend_x_q, pend_y_q;
    logic        pend_q;

    timing_t     tim_in, tim_s1_q, tim_s2_q, tim_out_q;
    logic [11:0] rgb_s1_q, rgb_s2_q, rgb_out_q;
    logic        win_s1_q, win_s2_q;
    logic [11:0] rom_addr_q;

    logic        frame_start;
    logic [12:0] h13, v13, ax13, ay13, rel_x, rel_y;
    logic        in_win;
    logic [11:0] addr_d;
    logic [11:0] rgb_d;

    assign tim_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                      vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

    assign frame_start = vsync_in && !vsync_q;

    // Position double buffer: pending copy on pos_valid, promoted at frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q  <= 1'b0;
            act_x_q  <= '0;
            act_y_q  <= '0;
            pend_x_q <= '0;
            pend_y_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            vsync_q <= vsync_in;
            if (frame_start && pos_valid) begin
                act_x_q <= xpos;
                act_y_q <= ypos;
                pend_q  <= 1'b0;
            end else if (frame_start && pend_q) begin
                act_x_q <= pend_x_q;
                act_y_q <= pend_y_q;
                pend_q  <= 1'b0;
            end else if (pos_valid) begin
                pend_x_q <= xpos;
                pend_y_q <= ypos;
                pend_q   <= 1'b1;
            end
        end
    end

    // Stage 0 window test, widened to 13 bits so subtraction never wraps
    always_comb begin
        h13    = {2'b00, hcount_in};
        v13    = {2'b00, vcount_in};
        ax13   = {1'b0, act_x_q};
        ay13   = {1'b0, act_y_q};
        rel_x  = h13 - ax13;
        rel_y  = v13 - ay13;
        in_win = !hblnk_in && !vblnk_in &&
                 (h13 >= ax13) && (rel_x < W13) &&
                 (v13 >= ay13) && (rel_y < H13);
        addr_d = in_win ? {rel_y[5:0], rel_x[5:0]} : 12'h000;
    end

    // Composite: ROM colour inside the window unless it is the transparent key
    always_comb begin
        rgb_d = rgb_s2_q;
        if (win_s2_q && !(TRANSP_EN && (rom.rom_rgb == TRANSP_COLOR)))
            rgb_d = rom.rom_rgb;
    end

    // Three-stage pipeline: S1 address, S2 ROM read, S3 output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tim_s1_q   <= '0;
            tim_s2_q   <= '0;
            tim_out_q  <= '0;
            rgb_s1_q   <= '0;
            rgb_s2_q   <= '0;
            rgb_out_q  <= '0;
            win_s1_q   <= 1'b0;
            win_s2_q   <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            tim_s1_q   <= tim_in;
            rgb_s1_q   <= rgb_in;
            win_s1_q   <= in_win;
            rom_addr_q <= addr_d;
            tim_s2_q   <= tim_s1_q;
            rgb_s2_q   <= rgb_s1_q;
            win_s2_q   <= win_s1_q;
            tim_out_q  <= tim_s2_q;
            rgb_out_q  <= rgb_d;
        end
    end

    assign rom.rom_addr = rom_addr_q;
    assign hcount_out   = tim_out_q.hcount;
    assign vcount_out   = tim_out_q.vcount;
    assign hsync_out    = tim_out_q.hsync;
    assign vsync_out    = tim_out_q.vsync;
    assign hblnk_out    = tim_out_q.hblnk;
    assign vblnk_out    = tim_out_q.vblnk;
    assign rgb_out      = rgb_out_q;

endmodule

// File: tb/tb_sprite_rom_reader.sv
// Directed bench for sprite_rom_reader. The ROM model returns
// addr + 12'hABC one clock after the address, so address 0 reads 12'hABC
// and address 12'h544 (y=21, x=4) reads the transparent key 12'h000.
module tb_sprite_rom_reader;

    logic        clk;
    logic        rst_n;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in, xpos, ypos;
    logic        pos_valid;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    int errors = 0;
    int checks = 0;

    localparam logic [11:0] BG = 12'h123;

    sprite_rom_reader_if rom_bus ();

    sprite_rom_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .xpos       (xpos),
        .ypos       (ypos),
        .pos_valid  (pos_valid),
        .rom        (rom_bus.master),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM model
    always_ff @(posedge clk) rom_bus.rom_rgb <= rom_bus.rom_addr + 12'hABC;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // advance n clocks, ending 1 time unit after the last rising edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int h, input int v, input logic hb, input logic vb);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = hb;
        vblnk_in  = vb;
    endtask

    // present one raster position, check address after S1 and colour after S3
    task automatic pix(input string tag, input int h, input int v,
                       input logic [11:0] exp_addr, input logic [11:0] exp_rgb);
        drive(h, v, 1'b0, 1'b0);
        tick(1);
        check({tag, "_addr"}, 16'(rom_bus.rom_addr), 16'(exp_addr));
        tick(2);
        check({tag, "_rgb"}, 16'(rgb_out), 16'(exp_rgb));
    endtask

    // pulse pos_valid (with vsync low), no frame start
    task automatic post_pos(input int x, input int y);
        xpos = 12'(x);
        ypos = 12'(y);
        pos_valid = 1'b1;
        tick(1);
        pos_valid = 1'b0;
    endtask

    task automatic frame_start();
        vsync_in = 1'b1;
        tick(1);
        vsync_in = 1'b0;
        tick(1);
    endtask

    initial begin
        rst_n = 1'b1;
        drive(100, 0, 1'b0, 1'b0);
        hsync_in = 1'b1; vsync_in = 1'b0;
        rgb_in = 12'h0F0; xpos = '0; ypos = '0; pos_valid = 1'b0;
        tick(4);

        // 1. asynchronous reset mid-line, then latency from release
        rst_n = 1'b0;
        #1;
        check("rst_rgb", 16'(rgb_out), 16'h0);
        check("rst_hcount", 16'(hcount_out), 16'h0);
        check("rst_hsync", 16'(hsync_out), 16'h0);
        check("rst_addr", 16'(rom_bus.rom_addr), 16'h0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("lat2_hcount", 16'(hcount_out), 16'h0);
        tick(1);
        check("lat3_hcount", 16'(hcount_out), 16'd100);
        check("lat3_rgb", 16'(rgb_out), 16'h0F0);
        check("lat3_hsync", 16'(hsync_out), 16'h1);
        hsync_in = 1'b0;
        rgb_in = BG;

        // 2. window and address at (200,100)
        post_pos(200, 100);
        frame_start();
        pix("corner0", 200, 100, 12'h000, 12'hABC);
        pix("corner1", 247, 163, 12'hFEF, 12'hAAB);
        pix("right_out", 248, 163, 12'h000, BG);
        pix("below_out", 200, 164, 12'h000, BG);
        pix("left_out", 199, 100, 12'h000, BG);

        // 3. transparency and blanking
        pix("transp", 204, 121, 12'h544, BG);
        drive(210, 110, 1'b1, 1'b0);
        tick(3);
        check("hblnk_rgb", 16'(rgb_out), 16'(BG));
        check("hblnk_out", 16'(hblnk_out), 16'h1);
        drive(210, 110, 1'b0, 1'b1);
        tick(3);
        check("vblnk_rgb", 16'(rgb_out), 16'(BG));
        check("vblnk_out", 16'(vblnk_out), 16'h1);
        check("vcount_out", 16'(vcount_out), 16'd110);

        // 4. frame-synchronous position update
        post_pos(300, 50);
        pix("old_pos", 200, 100, 12'h000, 12'hABC);
        pix("new_not_yet", 300, 50, 12'h000, BG);
        frame_start();
        pix("new_pos", 300, 50, 12'h000, 12'hABC);
        pix("old_gone", 200, 100, 12'h000, BG);
        xpos = 12'd400; ypos = 12'd200; pos_valid = 1'b1; vsync_in = 1'b1;
        tick(1);
        pos_valid = 1'b0; vsync_in = 1'b0;
        tick(1);
        pix("coincident", 400, 200, 12'h000, 12'hABC);
        post_pos(10, 10);
        post_pos(20, 20);
        frame_start();
        pix("last_wins", 20, 20, 12'h000, 12'hABC);
        pix("first_lost", 10, 10, 12'h000, BG);

        // 5. clipping
        post_pos(780, 0);
        frame_start();
        pix("clip_first", 780, 0, 12'h000, 12'hABC);
        pix("clip_last", 799, 0, 12'h013, 12'hACF);
        pix("clip_left", 779, 0, 12'h000, BG);
        drive(800, 0, 1'b1, 1'b0);
        tick(3);
        check("clip_hblnk", 16'(rgb_out), 16'(BG));
        post_pos(0, 12'hFFF);
        frame_start();
        pix("ywrap0", 0, 0, 12'h000, BG);
        pix("ywrap20", 10, 20, 12'h000, BG);

        // 6. reset while drawing
        post_pos(300, 50);
        frame_start();
        drive(300, 50, 1'b0, 1'b0);
        tick(3);
        check("pre_rst_draw", 16'(rgb_out), 16'hABC);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rgb", 16'(rgb_out), 16'h0);
        check("mid_rst_vcount", 16'(vcount_out), 16'h0);
        tick(2);
        rst_n = 1'b1;
        pix("post_rst_origin", 0, 0, 12'h000, 12'hABC);
        post_pos(300, 50);
        pix("post_rst_pending", 0, 0, 12'h000, 12'hABC);
        frame_start();
        pix("post_rst_applied", 0, 0, 12'h000, BG);
        pix("post_rst_newpos", 300, 50, 12'h000, 12'hABC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
